// File: rtl/load_store_unit.sv
// load_store_unit
//
// Memory-side half of the load/store path. It takes one load or store from
// the execute stage (effective address, RV32I funct_3 width code, rs2 data),
// runs a single access on the data-memory bus with a grant/response
// handshake, and returns extended load data or a store acknowledgement.
// While an access is outstanding, req_ready stays low so the pipeline stalls.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   req_valid / req_ready      request handshake from the pipeline
//   is_store, funct_3          access type and width/sign code
//   addr, wdata                effective byte address and rs2 store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       extended load data and error flag
//   mem_req, mem_we            bus request (held until mem_gnt) and write flag
//   mem_addr, mem_be           word address and byte enables
//   mem_wdata                  lane-replicated store data
//   mem_gnt, mem_rvalid        bus grant and read-data / write-ack strobe
//   mem_rdata                  raw word read data
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct_3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The counter is checked before incrementing, so the last WAIT cycle is
  // the one where it holds TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             store_q, store_next;
  logic [2:0]       f3_q, f3_next;
  logic [1:0]       off_q, off_next;

  logic             resp_valid_next, resp_err_next;
  logic [31:0]      resp_rdata_next;
  logic             mem_req_next, mem_we_next;
  logic [31:0]      mem_addr_next, mem_wdata_next;
  logic [3:0]       mem_be_next;

  logic             dec_err;
  logic [3:0]       dec_be;
  logic [31:0]      dec_wdata;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;

  assign req_ready = (state == IDLE) && !reset;

  // Decode of the incoming request: legality, byte enables, store lanes.
  always_comb begin
    dec_err   = 1'b0;
    dec_be    = 4'b0000;
    dec_wdata = 32'h0;
    case (funct_3)
      3'b000: begin
        dec_be    = 4'b0001 << addr[1:0];
        dec_wdata = {4{wdata[7:0]}};
      end
      3'b001: begin
        dec_err   = addr[0];
        dec_be    = addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {2{wdata[15:0]}};
      end
      3'b010: begin
        dec_err   = (addr[1:0] != 2'b00);
        dec_be    = 4'b1111;
        dec_wdata = wdata;
      end
      3'b100: begin
        dec_err = is_store;
        dec_be  = 4'b0001 << addr[1:0];
      end
      3'b101: begin
        dec_err = is_store | addr[0];
        dec_be  = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: dec_err = 1'b1;
    endcase
    if (!is_store) dec_wdata = 32'h0;
  end

  // Load extraction; halves are always aligned so addr[1] picks the lane.
  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next state and next values of every registered output. Bus fields are
  // only non-zero while a request is being presented.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    store_next      = store_q;
    f3_next         = f3_q;
    off_next        = off_q;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = 32'h0;
    mem_req_next    = 1'b0;
    mem_we_next     = 1'b0;
    mem_addr_next   = 32'h0;
    mem_be_next     = 4'b0000;
    mem_wdata_next  = 32'h0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          store_next = is_store;
          f3_next    = funct_3;
          off_next   = addr[1:0];
          if (dec_err) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else begin
            state_next     = REQ;
            mem_req_next   = 1'b1;
            mem_we_next    = is_store;
            mem_addr_next  = {addr[31:2], 2'b00};
            mem_be_next    = dec_be;
            mem_wdata_next = dec_wdata;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else begin
          mem_req_next   = 1'b1;
          mem_we_next    = mem_we;
          mem_addr_next  = mem_addr;
          mem_be_next    = mem_be;
          mem_wdata_next = mem_wdata;
        end
      end
      WAIT: begin
        // Data arriving on the limit cycle still counts as success.
        if (mem_rvalid) begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_rdata_next = store_q ? 32'h0 : ld_data;
        end else if (cnt == CNT_LIMIT) begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      store_q    <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'h0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      store_q    <= store_next;
      f3_q       <= f3_next;
      off_q      <= off_next;
      resp_valid <= resp_valid_next;
      resp_err   <= resp_err_next;
      resp_rdata <= resp_rdata_next;
      mem_req    <= mem_req_next;
      mem_we     <= mem_we_next;
      mem_addr   <= mem_addr_next;
      mem_be     <= mem_be_next;
      mem_wdata  <= mem_wdata_next;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//
// Directed bench for load_store_unit: loads and stores of every width,
// error requests, grant stall with timeout, data-on-limit-cycle success,
// and reset in the middle of an access. Expected values are hand-computed.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct_3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checkCount = 0;
  int passCount  = 0;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct_3(funct_3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; outputs are settled here.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; returns in the cycle after acceptance.
  task automatic applyStimulus(input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    checkOutput("ready_before_req", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    is_store  = st;
    funct_3   = f3;
    addr      = a;
    wdata     = wd;
    stepCycle();
    req_valid = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
  endtask

  // Drive a full bus access after applyStimulus and check every step.
  task automatic runAccess(input string tag, input int gntWait, input logic [31:0] rd,
                           input logic expWe, input logic [31:0] expAddr,
                           input logic [3:0] expBe, input logic [31:0] expWdata,
                           input logic [31:0] expRdata);
    for (int i = 0; i <= gntWait; i++) begin
      checkOutput({tag, "_mem_req"}, {31'h0, mem_req}, 32'h1);
      checkOutput({tag, "_mem_we"}, {31'h0, mem_we}, {31'h0, expWe});
      checkOutput({tag, "_mem_addr"}, mem_addr, expAddr);
      checkOutput({tag, "_mem_be"}, {28'h0, mem_be}, {28'h0, expBe});
      checkOutput({tag, "_mem_wdata"}, mem_wdata, expWdata);
      checkOutput({tag, "_busy_ready"}, {31'h0, req_ready}, 32'h0);
      mem_gnt = (i == gntWait);
      stepCycle();
    end
    mem_gnt = 1'b0;
    checkOutput({tag, "_req_dropped"}, {31'h0, mem_req}, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    stepCycle();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    checkOutput({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h1);
    checkOutput({tag, "_resp_err"}, {31'h0, resp_err}, 32'h0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, expRdata);
    checkOutput({tag, "_resp_ready"}, {31'h0, req_ready}, 32'h0);
    stepCycle();
    checkOutput({tag, "_pulse_end"}, {31'h0, resp_valid}, 32'h0);
    checkOutput({tag, "_ready_again"}, {31'h0, req_ready}, 32'h1);
  endtask

  // Request that must be rejected immediately without touching the bus.
  task automatic runError(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a);
    applyStimulus(st, f3, a, 32'h5555_AAAA);
    checkOutput({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h1);
    checkOutput({tag, "_resp_err"}, {31'h0, resp_err}, 32'h1);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    checkOutput({tag, "_no_mem_req"}, {31'h0, mem_req}, 32'h0);
    stepCycle();
    checkOutput({tag, "_pulse_end"}, {31'h0, resp_valid}, 32'h0);
    checkOutput({tag, "_still_no_req"}, {31'h0, mem_req}, 32'h0);
    checkOutput({tag, "_ready_again"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    req_valid  = 1'b0;
    is_store   = 1'b0;
    funct_3    = 3'b000;
    addr       = 32'h0;
    wdata      = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;

    // Reset state, with a stale rvalid present that must be ignored.
    stepCycle();
    stepCycle();
    checkOutput("rst_ready", {31'h0, req_ready}, 32'h0);
    checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("rst_mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("rst_mem_be", {28'h0, mem_be}, 32'h0);
    reset = 1'b0;
    stepCycle();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    checkOutput("post_rst_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("post_rst_stale_rvalid", {31'h0, resp_valid}, 32'h0);

    // Loads and stores of each width with immediate grant.
    applyStimulus(1'b0, 3'b000, 32'h0000_1003, 32'h0);
    runAccess("lb", 0, 32'h80FF_0000, 1'b0, 32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    applyStimulus(1'b0, 3'b101, 32'h0000_2002, 32'h0);
    runAccess("lhu", 0, 32'h8001_1234, 1'b0, 32'h0000_2000, 4'b1100, 32'h0, 32'h0000_8001);
    applyStimulus(1'b0, 3'b001, 32'h0000_7000, 32'h0);
    runAccess("lh", 0, 32'h0000_F00D, 1'b0, 32'h0000_7000, 4'b0011, 32'h0, 32'hFFFF_F00D);
    applyStimulus(1'b0, 3'b100, 32'h0000_7002, 32'h0);
    runAccess("lbu", 0, 32'h00AB_0000, 1'b0, 32'h0000_7000, 4'b0100, 32'h0, 32'h0000_00AB);
    applyStimulus(1'b1, 3'b000, 32'h0000_3001, 32'hAABB_CCDD);
    runAccess("sb", 0, 32'h1234_5678, 1'b1, 32'h0000_3000, 4'b0010, 32'hDDDD_DDDD, 32'h0);
    applyStimulus(1'b1, 3'b001, 32'h0000_3002, 32'hAABB_CCDD);
    runAccess("sh", 1, 32'h0, 1'b1, 32'h0000_3000, 4'b1100, 32'hCCDD_CCDD, 32'h0);
    applyStimulus(1'b1, 3'b010, 32'h0000_3000, 32'h0123_4567);
    runAccess("sw", 0, 32'h0, 1'b1, 32'h0000_3000, 4'b1111, 32'h0123_4567, 32'h0);

    // Requests rejected without a bus cycle.
    runError("lw_misaligned", 1'b0, 3'b010, 32'h0000_4002);
    runError("store_f3_3", 1'b1, 3'b011, 32'h0000_4000);
    runError("load_f3_6", 1'b0, 3'b110, 32'h0000_4000);
    runError("lh_odd", 1'b0, 3'b001, 32'h0000_4001);

    // Grant withheld three cycles, then no response: timeout error.
    applyStimulus(1'b0, 3'b010, 32'h0000_5000, 32'h0);
    n = 0;
    while (mem_req && n < 10) begin
      checkOutput("to_stall_addr", mem_addr, 32'h0000_5000);
      checkOutput("to_stall_be", {28'h0, mem_be}, 32'hF);
      mem_gnt = (n == 3);
      stepCycle();
      n++;
    end
    mem_gnt = 1'b0;
    checkOutput("to_req_cycles", n, 4);
    n = 1;
    while (!resp_valid && n < 40) begin
      stepCycle();
      n++;
    end
    checkOutput("to_resp_delay", n, 17);
    checkOutput("to_resp_err", {31'h0, resp_err}, 32'h1);
    checkOutput("to_resp_rdata", resp_rdata, 32'h0);
    stepCycle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    stepCycle();
    mem_rvalid = 1'b0;
    checkOutput("late_rvalid_ignored", {31'h0, resp_valid}, 32'h0);
    checkOutput("late_rvalid_ready", {31'h0, req_ready}, 32'h1);

    // Read data on the limit cycle wins over the timeout.
    applyStimulus(1'b0, 3'b010, 32'h0000_8004, 32'h0);
    mem_gnt = 1'b1;
    stepCycle();
    mem_gnt = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (resp_valid) checkOutput("edge_early_resp", {31'h0, resp_valid}, 32'h0);
      stepCycle();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    stepCycle();
    mem_rvalid = 1'b0;
    checkOutput("edge_resp_valid", {31'h0, resp_valid}, 32'h1);
    checkOutput("edge_resp_err", {31'h0, resp_err}, 32'h0);
    checkOutput("edge_resp_rdata", resp_rdata, 32'hCAFE_F00D);
    stepCycle();

    // Reset while waiting for data, then a stray rvalid.
    applyStimulus(1'b1, 3'b010, 32'h0000_6000, 32'h1111_2222);
    mem_gnt = 1'b1;
    stepCycle();
    mem_gnt = 1'b0;
    reset = 1'b1;
    stepCycle();
    checkOutput("midrst_mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("midrst_mem_we", {31'h0, mem_we}, 32'h0);
    checkOutput("midrst_mem_addr", mem_addr, 32'h0);
    checkOutput("midrst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("midrst_ready_low", {31'h0, req_ready}, 32'h0);
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    stepCycle();
    mem_rvalid = 1'b0;
    checkOutput("midrst_ready_high", {31'h0, req_ready}, 32'h1);
    checkOutput("midrst_no_resp", {31'h0, resp_valid}, 32'h0);
    stepCycle();
    checkOutput("midrst_still_no_resp", {31'h0, resp_valid}, 32'h0);
    checkOutput("midrst_resp_rdata", resp_rdata, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
